cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_storage.sv | 47 ++++
 rtl/cache_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, address field layout and FSM state encoding
// for the direct-mapped read-only cache controller.
package cache_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int SETS        = 1024;

    localparam int ADDR_W      = 15;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 10;
    localparam int OFFSET_W    = 2;

    localparam int OFFSET_LSB  = 0;
    localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB     = INDEX_LSB + INDEX_W;

    localparam int WAIT_W      = 4;
    localparam int LINE_WORDS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/cache_storage.sv
// Tag, data and valid arrays for the direct-mapped cache.
// Asynchronous read by index, whole-line write on refill.
module cache_storage #(
    parameter int WORD_LENGTH = cache_pkg::WORD_LENGTH,
    parameter int SETS        = cache_pkg::SETS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [cache_pkg::INDEX_W-1:0]         rindex,
    output logic                                  rvalid,
    output logic [cache_pkg::TAG_W-1:0]           rtag,
    output logic [3:0][WORD_LENGTH-1:0]           rline,
    input  logic                                  we,
    input  logic [cache_pkg::INDEX_W-1:0]         windex,
    input  logic [cache_pkg::TAG_W-1:0]           wtag,
    input  logic [3:0][WORD_LENGTH-1:0]           wline
);

    logic [SETS-1:0]                valid_q;
    logic [cache_pkg::TAG_W-1:0]    tag_q  [SETS];
    logic [3:0][WORD_LENGTH-1:0]    data_q [SETS];

    // Valid bits clear on reset; a refill marks its line valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[windex] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[windex]  <= wtag;
            data_q[windex] <= wline;
        end
    end

    // Combinational lookup port.
    always_comb begin
        rvalid = valid_q[rindex];
        rtag   = tag_q[rindex];
        rline  = data_q[rindex];
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, read-only cache controller with a fixed-latency
// refill from a four-word-wide main memory.
module cache_controller #(
    parameter int WORD_LENGTH = cache_pkg::WORD_LENGTH,
    parameter int SETS        = cache_pkg::SETS,
    parameter int MEM_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req,
    input  logic [cache_pkg::ADDR_W-1:0]  cpu_addr,
    output logic                          cpu_ready,
    output logic                          cpu_rvalid,
    output logic [WORD_LENGTH-1:0]        cpu_rdata,
    output logic [cache_pkg::ADDR_W-1:0]  mem_address,
    output logic                          mem_hit,
    input  logic [WORD_LENGTH-1:0]        mem_data1,
    input  logic [WORD_LENGTH-1:0]        mem_data2,
    input  logic [WORD_LENGTH-1:0]        mem_data3,
    input  logic [WORD_LENGTH-1:0]        mem_data4,
    output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count
);

    import cache_pkg::*;

    state_e                      state, state_nx;
    logic [ADDR_W-1:0]           addr_q;
    logic [WAIT_W-1:0]           wait_q;

    logic [TAG_W-1:0]            tag;
    logic [INDEX_W-1:0]          index;
    logic [OFFSET_W-1:0]         offset;

    logic                        s_valid;
    logic [TAG_W-1:0]            s_tag;
    logic [3:0][WORD_LENGTH-1:0] s_line;
    logic [3:0][WORD_LENGTH-1:0] fill_line;

    logic accept, lookup, hit, capture;

    assign tag       = addr_q[TAG_LSB +: TAG_W];
    assign index     = addr_q[INDEX_LSB +: INDEX_W];
    assign offset    = addr_q[OFFSET_LSB +: OFFSET_W];
    assign fill_line = {mem_data4, mem_data3, mem_data2, mem_data1};

    assign accept  = (state == IDLE) && cpu_req;
    assign lookup  = (state == LOOKUP);
    assign hit     = s_valid && (s_tag == tag);
    assign capture = (state == MISS_WAIT) && (wait_q == '0);

    assign mem_address = addr_q;

    cache_storage #(
        .WORD_LENGTH (WORD_LENGTH),
        .SETS        (SETS)
    ) u_storage (
        .clk    (clk),
        .rst_n  (rst_n),
        .rindex (index),
        .rvalid (s_valid),
        .rtag   (s_tag),
        .rline  (s_line),
        .we     (capture),
        .windex (index),
        .wtag   (tag),
        .wline  (fill_line)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (cpu_req) state_nx = LOOKUP;
            LOOKUP:    state_nx = hit ? DONE : MISS_WAIT;
            MISS_WAIT: if (wait_q == '0) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Moore outputs: ready in IDLE, memory enabled only while waiting.
    always_comb begin
        cpu_ready = (state == IDLE);
        mem_hit   = (state != MISS_WAIT);
    end

    // Request latch, response data, wait counter and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wait_q     <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (accept) begin
                addr_q <= cpu_addr;
            end
            if (lookup && hit) begin
                cpu_rdata  <= s_line[offset];
                cpu_rvalid <= 1'b1;
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end
            if (lookup && !hit) begin
                wait_q <= WAIT_W'(MEM_LATENCY - 1);
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
            if ((state == MISS_WAIT) && (wait_q != '0)) begin
                wait_q <= wait_q - 1'b1;
            end
            if (capture) begin
                cpu_rdata  <= fill_line[offset];
                cpu_rvalid <= 1'b1;
            end
        end
    end

endmodule
